outer_loop_seq: RTL

OUTER_LOOP_SEQ -- requirements
Module: outer_loop_seq

---
 rtl/outer_loop_seq.sv | 109 ++++++++++
 1 files changed

// File: rtl/outer_loop_seq.sv
// Outer-loop sequencer: drives an external inner counter for CNT iterations.
// Latency: GO -> INNER_LD one cycle later; final INNER_DONE -> DONE one cycle later.
// Backpressure: PAUSE gates INNER_GO only; LD/GO are ignored while busy.
//
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   ld_i, din_i           load outer count (idle only, wins over go_i)
//   go_i, abort_i         start / terminate the sequence
//   pause_i               suspends inner_go_o while running
//   inner_done_i          end-of-inner-loop pulse (counted only in RUN)
//   inner_ld_o, inner_go_o  inner counter reload strobe and run enable
//   cnt_o, zero_o         current outer count and its zero flag
//   busy_o, done_o        not-idle flag and one-cycle completion pulse
//
// Optional feature: OUTER_ZERO_IS_256_EN -- a count of 0 runs 256 loops
// instead of completing immediately.
module outer_loop_seq (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       ld_i,
    input  logic [7:0] din_i,
    input  logic       go_i,
    input  logic       abort_i,
    input  logic       pause_i,
    input  logic       inner_done_i,
    output logic       inner_ld_o,
    output logic       inner_go_o,
    output logic [7:0] cnt_o,
    output logic       zero_o,
    output logic       busy_o,
    output logic       done_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOADI = 2'd1,
        RUN   = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       inner_ld_q, run_q, busy_q, done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (ld_i) begin
                    cnt_d = din_i;
                end else if (go_i) begin
`ifdef OUTER_ZERO_IS_256_EN
                    state_d = LOADI;
`else
                    // A zero count has nothing to iterate: complete at once.
                    state_d = (cnt_q == 8'd0) ? FIN : LOADI;
`endif
                end
            end
            LOADI: begin
                state_d = abort_i ? IDLE : RUN;
            end
            RUN: begin
                // Abort wins over a coincident inner_done; count is kept.
                if (abort_i) begin
                    state_d = IDLE;
                end else if (inner_done_i) begin
                    cnt_d   = cnt_q - 8'd1;
                    state_d = (cnt_q == 8'd1) ? FIN : LOADI;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they line up
    // exactly with the state they describe.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            inner_ld_q <= 1'b0;
            run_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            inner_ld_q <= (state_d == LOADI);
            run_q      <= (state_d == RUN);
            busy_q     <= (state_d != IDLE);
            done_q     <= (state_d == FIN);
        end
    end

    assign inner_ld_o = inner_ld_q;
    assign inner_go_o = run_q & ~pause_i;
    assign cnt_o      = cnt_q;
    assign zero_o     = (cnt_q == 8'd0);
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule
